// File: rtl/motor_pwm_driver_pkg.sv
// Shared types and default widths for the two-channel soft-start motor PWM driver.
package motor_pwm_driver_pkg;

    localparam int unsigned CNT_W_DEF    = 8;
    localparam int unsigned DUTY_MAX_DEF = 255;
    localparam int unsigned STEP_DEF     = 8;
    localparam int unsigned RAMP_DIV_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_RUN  = 2'd2,
        ST_DOWN = 2'd3
    } ramp_state_e;

endpackage

// File: rtl/motor_ramp_channel.sv
// One motor channel: soft-start/soft-stop duty ramp with a period-aligned duty shadow.
module motor_ramp_channel
    import motor_pwm_driver_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned DUTY_MAX = DUTY_MAX_DEF,
    parameter int unsigned STEP     = STEP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              tick,
    input  logic              pwm_cnt_wrap,
    output ramp_state_e       state,
    output logic [CNT_W-1:0]  duty_act
);

    localparam int unsigned EXT_W = CNT_W + 1;
    localparam logic [EXT_W-1:0] STEP_X = EXT_W'(STEP);
    localparam logic [EXT_W-1:0] DMAX_X = EXT_W'(DUTY_MAX);

    ramp_state_e        state_nxt;
    logic [CNT_W-1:0]   duty;
    logic [CNT_W-1:0]   duty_nxt;
    logic [CNT_W-1:0]   duty_act_nxt;
    logic [EXT_W-1:0]   duty_x;
    logic [EXT_W-1:0]   up_sum;
    logic [EXT_W-1:0]   up_sat;
    logic [EXT_W-1:0]   dn_sat;

    // Saturating step arithmetic in one extra bit so neither direction can wrap.
    always_comb begin
        duty_x = {1'b0, duty};
        up_sum = duty_x + STEP_X;
        up_sat = (up_sum > DMAX_X) ? DMAX_X : up_sum;
        dn_sat = (duty_x > STEP_X) ? (duty_x - STEP_X) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            duty     <= '0;
            duty_act <= '0;
        end else begin
            state    <= state_nxt;
            duty     <= duty_nxt;
            duty_act <= duty_act_nxt;
        end
    end

    // Request edges beat the ramp tick, so short pulses always move the state.
    always_comb begin
        state_nxt    = state;
        duty_nxt     = duty;
        duty_act_nxt = pwm_cnt_wrap ? duty : duty_act;

        case (state)
            ST_IDLE: begin
                duty_nxt = '0;
                if (req) begin
                    state_nxt = ST_UP;
                end
            end
            ST_UP: begin
                if (!req) begin
                    state_nxt = ST_DOWN;
                end else if (tick) begin
                    duty_nxt = CNT_W'(up_sat);
                    if (up_sat == DMAX_X) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                duty_nxt = CNT_W'(DUTY_MAX);
                if (!req) begin
                    state_nxt = ST_DOWN;
                end
            end
            ST_DOWN: begin
                if (req) begin
                    state_nxt = ST_UP;
                end else if (tick) begin
                    duty_nxt = CNT_W'(dn_sat);
                    if (dn_sat == '0) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                duty_nxt  = '0;
            end
        endcase
    end

endmodule

// File: rtl/motor_pwm_driver.sv
// Two independent soft-start DC-motor PWM channels driven by the turn FSM's LEFT/RIGHT requests.
module motor_pwm_driver
    import motor_pwm_driver_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned DUTY_MAX = DUTY_MAX_DEF,
    parameter int unsigned STEP     = STEP_DEF,
    parameter int unsigned RAMP_DIV = RAMP_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic left,
    input  logic right,
    output logic pwm_left,
    output logic pwm_right,
    output logic busy_left,
    output logic busy_right,
    output logic full_left,
    output logic full_right
);

    localparam int unsigned RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);

    logic [CNT_W-1:0]  pwm_cnt;
    logic [RAMP_W-1:0] ramp_cnt;
    logic              tick;
    logic              pwm_cnt_wrap;
    ramp_state_e       state_left;
    ramp_state_e       state_right;
    logic [CNT_W-1:0]  duty_act_left;
    logic [CNT_W-1:0]  duty_act_right;

    assign tick         = (ramp_cnt == RAMP_LAST);
    assign pwm_cnt_wrap = &pwm_cnt;

    // Shared PWM period counter and ramp-tick divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt  <= '0;
            ramp_cnt <= '0;
        end else begin
            pwm_cnt  <= pwm_cnt + CNT_W'(1);
            ramp_cnt <= tick ? '0 : (ramp_cnt + RAMP_W'(1));
        end
    end

    motor_ramp_channel #(
        .CNT_W    (CNT_W),
        .DUTY_MAX (DUTY_MAX),
        .STEP     (STEP)
    ) u_left (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (left),
        .tick         (tick),
        .pwm_cnt_wrap (pwm_cnt_wrap),
        .state        (state_left),
        .duty_act     (duty_act_left)
    );

    motor_ramp_channel #(
        .CNT_W    (CNT_W),
        .DUTY_MAX (DUTY_MAX),
        .STEP     (STEP)
    ) u_right (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (right),
        .tick         (tick),
        .pwm_cnt_wrap (pwm_cnt_wrap),
        .state        (state_right),
        .duty_act     (duty_act_right)
    );

    // Registered compare keeps the motor outputs glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_left  <= 1'b0;
            pwm_right <= 1'b0;
        end else begin
            pwm_left  <= (pwm_cnt < duty_act_left);
            pwm_right <= (pwm_cnt < duty_act_right);
        end
    end

    assign busy_left  = (state_left  != ST_IDLE);
    assign busy_right = (state_right != ST_IDLE);
    assign full_left  = (state_left  == ST_RUN);
    assign full_right = (state_right == ST_RUN);

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Self-checking bench for motor_pwm_driver: vector table, corner-case sequences and random requests vs a reference model.
module tb_motor_pwm_driver;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned DUTY_MAX = 12;
    localparam int unsigned STEP     = 4;
    localparam int unsigned RAMP_DIV = 2;
    localparam int          PERIOD   = 16;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_RUN  = 2;
    localparam int M_DOWN = 3;

    logic clk;
    logic rst_n;
    logic left;
    logic right;
    logic pwm_left;
    logic pwm_right;
    logic busy_left;
    logic busy_right;
    logic full_left;
    logic full_right;

    int n_checks;
    int n_errors;

    int m_cnt;
    int m_rcnt;
    int m_st   [2];
    int m_duty [2];
    int m_act  [2];
    bit m_pwm  [2];

    typedef struct {
        logic l;
        logic r;
        int   cycles;
        logic busy_l;
        logic full_l;
        logic busy_r;
        logic full_r;
    } vec_t;

    vec_t vecs [10];

    motor_pwm_driver #(
        .CNT_W    (CNT_W),
        .DUTY_MAX (DUTY_MAX),
        .STEP     (STEP),
        .RAMP_DIV (RAMP_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .left       (left),
        .right      (right),
        .pwm_left   (pwm_left),
        .pwm_right  (pwm_right),
        .busy_left  (busy_left),
        .busy_right (busy_right),
        .full_left  (full_left),
        .full_right (full_right)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_cnt  = 0;
        m_rcnt = 0;
        for (int c = 0; c < 2; c++) begin
            m_st[c]   = M_IDLE;
            m_duty[c] = 0;
            m_act[c]  = 0;
            m_pwm[c]  = 1'b0;
        end
    endfunction

    // One clock edge of the behavioural model, from the rules stated in plain integer arithmetic.
    function automatic void model_step(input logic req_l, input logic req_r);
        bit tick;
        bit wrap;
        bit req;
        tick = (m_rcnt == RAMP_DIV - 1);
        wrap = (m_cnt == PERIOD - 1);
        for (int c = 0; c < 2; c++) begin
            req = (c == 0) ? req_l : req_r;
            m_pwm[c] = (m_cnt < m_act[c]);
            if (wrap) m_act[c] = m_duty[c];
            case (m_st[c])
                M_IDLE: begin
                    m_duty[c] = 0;
                    if (req) m_st[c] = M_UP;
                end
                M_UP: begin
                    if (!req) m_st[c] = M_DOWN;
                    else if (tick) begin
                        m_duty[c] = (m_duty[c] + STEP > DUTY_MAX) ? DUTY_MAX : m_duty[c] + STEP;
                        if (m_duty[c] == DUTY_MAX) m_st[c] = M_RUN;
                    end
                end
                M_RUN: begin
                    m_duty[c] = DUTY_MAX;
                    if (!req) m_st[c] = M_DOWN;
                end
                default: begin
                    if (req) m_st[c] = M_UP;
                    else if (tick) begin
                        m_duty[c] = (m_duty[c] < STEP) ? 0 : m_duty[c] - STEP;
                        if (m_duty[c] == 0) m_st[c] = M_IDLE;
                    end
                end
            endcase
        end
        m_cnt  = (m_cnt + 1) % PERIOD;
        m_rcnt = (m_rcnt + 1) % RAMP_DIV;
    endfunction

    task automatic compare_model();
        check("pwm_left",   pwm_left,   m_pwm[0]);
        check("pwm_right",  pwm_right,  m_pwm[1]);
        check("busy_left",  busy_left,  m_st[0] != M_IDLE);
        check("busy_right", busy_right, m_st[1] != M_IDLE);
        check("full_left",  full_left,  m_st[0] == M_RUN);
        check("full_right", full_right, m_st[1] == M_RUN);
    endtask

    task automatic step();
        @(posedge clk);
        model_step(left, right);
        #1;
        compare_model();
    endtask

    // Asynchronous reset asserted between edges; released so the next edge is cycle 1.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_pwm_left",   pwm_left,   1'b0);
        check("rst_pwm_right",  pwm_right,  1'b0);
        check("rst_busy_left",  busy_left,  1'b0);
        check("rst_busy_right", busy_right, 1'b0);
        check("rst_full_left",  full_left,  1'b0);
        check("rst_full_right", full_right, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_both_full(input bit need_l, input bit need_r, input string name);
        int guard;
        guard = 0;
        while (((need_l && !full_left) || (need_r && !full_right)) && guard < 60) begin
            step();
            guard++;
        end
        check_int({name, "_timeout"}, guard < 60 ? 1 : 0, 1);
    endtask

    initial begin
        int hi;
        int hi_b;
        int guard;
        n_checks = 0;
        n_errors = 0;
        left  = 1'b0;
        right = 1'b0;
        rst_n = 1'b0;
        model_reset();

        vecs[0] = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0};

        @(posedge clk);
        #1;
        do_reset();

        // Vector table: state flags after each held input pattern.
        for (int i = 0; i < 10; i++) begin
            left  = vecs[i].l;
            right = vecs[i].r;
            repeat (vecs[i].cycles) step();
            check($sformatf("vec%0d_busy_l", i), busy_left,  vecs[i].busy_l);
            check($sformatf("vec%0d_full_l", i), full_left,  vecs[i].full_l);
            check($sformatf("vec%0d_busy_r", i), busy_right, vecs[i].busy_r);
            check($sformatf("vec%0d_full_r", i), full_right, vecs[i].full_r);
        end

        // Ramp up and steady duty of 12/16.
        do_reset();
        left = 1'b1;
        wait_both_full(1'b1, 1'b0, "ramp_up");
        repeat (40) step();
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            step();
            hi += int'(pwm_left);
        end
        check_int("steady_high_time", hi, 12);

        // Mid-run reset, then quiet outputs with no requests.
        do_reset();
        left = 1'b0;
        hi = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            hi += int'(pwm_left) + int'(pwm_right);
        end
        check_int("post_reset_quiet", hi, 0);

        // Ramp down from RUN until idle and silent.
        left = 1'b1;
        wait_both_full(1'b1, 1'b0, "ramp_down_setup");
        repeat (40) step();
        left = 1'b0;
        step();
        check("drop_full_left", full_left, 1'b0);
        check("drop_busy_left", busy_left, 1'b1);
        guard = 0;
        while (busy_left && guard < 20) begin
            step();
            guard++;
        end
        check_int("ramp_down_timeout", guard < 20 ? 1 : 0, 1);
        repeat (32) step();
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            step();
            hi += int'(pwm_left);
        end
        check_int("after_down_high_time", hi, 0);

        // Reversal: short request, drop, re-request mid ramp-down.
        do_reset();
        left = 1'b1;
        repeat (3) step();
        left = 1'b0;
        step();
        check("rev_down_busy", busy_left, 1'b1);
        check("rev_down_full", full_left, 1'b0);
        left = 1'b1;
        step();
        check("rev_up_busy", busy_left, 1'b1);
        wait_both_full(1'b1, 1'b0, "reversal");

        // Independence: staggered requests, identical waveforms once both run.
        do_reset();
        left = 1'b1;
        repeat (5) step();
        right = 1'b1;
        wait_both_full(1'b1, 1'b1, "independence");
        repeat (40) step();
        for (int i = 0; i < 32; i++) begin
            step();
            check("indep_same_pwm", pwm_right, pwm_left);
        end
        left  = 1'b0;
        right = 1'b0;

        // Glitch-free: duty starts changing at pwm_cnt=7, output waits for the next period.
        do_reset();
        hi   = 0;
        hi_b = 0;
        for (int k = 1; k <= 64; k++) begin
            if (k == 39) left = 1'b1;
            step();
            if (k >= 33 && k <= 48) hi   += int'(pwm_left);
            if (k >= 49)            hi_b += int'(pwm_left);
        end
        check_int("glitch_cur_period", hi, 0);
        check_int("glitch_next_period", hi_b, 12);

        // Random request streams on both channels against the model.
        do_reset();
        for (int s = 0; s < 40; s++) begin
            left  = 1'($urandom_range(0, 1));
            right = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 24)) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
